dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the multicycle CPU core's data port.
- Owns a word-organised data RAM and performs byte, halfword and word loads and stores, with sign or zero extension on loads.
- Sub-word stores are done as read-modify-write (RMW).
- Uses a valid/ready request and single-pulse response handshake so the core controller can stall on memory.

Parameters:
- ADDR_WIDTH, 11, log2 of RAM depth in 32-bit words (2048 words).
- BASE_ADDR, 32'h1001_0000, byte address mapped to RAM word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; equals (state==IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sub-word data taken from the LSBs.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid: misaligned, out of range, or illegal size.

Behaviour:
- Accept: an accept occurs at an edge with req_valid & req_ready. All request fields are latched on that edge; inputs are don't-care afterwards.
- Address mapping:
  - off = req_addr - BASE_ADDR (32-bit wrap).
  - In range iff off < 4*2^ADDR_WIDTH.
  - idx = off[ADDR_WIDTH+1:2], lane = off[1:0].
- Byte order is little-endian: lane 0 = bits[7:0], halfword at lane 2 = bits[31:16].
- Error conditions:
  - half with lane[0]=1
  - word with lane!=0
  - req_size=11
  - out of range
- States: IDLE, LOAD, MERGE.
- IDLE, on accept:
  - Error: no RAM access, state stays IDLE; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Word store: mem[idx]<=req_wdata at the accept edge; rsp_valid pulses at T+1; state stays IDLE.
  - Load: rd_word<=mem[idx] (synchronous read) at the accept edge, state->LOAD. At the LOAD edge, rsp_rdata<=extract(rd_word, lane, size, sign), rsp_valid<=1, state->IDLE. Response is visible at T+2.
  - Byte/half store: rd_word<=mem[idx], state->MERGE. At the MERGE edge, mem[idx]<=merge(rd_word, wdata, lane, size), rsp_valid<=1, state->IDLE. Response is visible at T+2. Untouched bytes are preserved exactly.
- rsp_valid is high for exactly one cycle per accepted request.
- In the rsp_valid cycle the state is already IDLE, so req_ready=1 and back-to-back requests are allowed.
- The response is not back-pressured; the consumer must sample it in the pulse cycle.
- Load extension:
  - Signed byte replicates bit 7; signed half replicates bit 15.
  - Zero extension otherwise.
  - req_sign is ignored for word loads and for all stores.
- Ordering: a store followed by a load of the same word returns the post-store data; the RAM write always precedes the next read edge.
- RAM contents: not reset, no initialisation requirement. Reads of never-written words are X in simulation only.
- Reset: asserting rstn low at any time forces state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, and clears latched request registers.
  - A pending MERGE write is abandoned; RAM is unchanged by it.
  - Completed writes persist across reset.
- req_ready is combinational from state only, with no dependence on req_valid.

Decomposition:
- Shared package: size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL, state encoding, BASE_ADDR default.
- Sub-module: dmem_byte_lane (combinational) implements extract() and merge() from word, lane, size, sign and wdata. It is unit-testable separately.
- The FSM and RAM array stay in dmem_ctrl.

Test Plan:
1. Word store 0xDEADBEEF @0x10010004, then word load @0x10010004 -> store rsp at T+1, err=0; load rsp at T+2, rdata=0xDEADBEEF.
2. Byte store 0x80 @0x10010005 over 0xDEADBEEF, then signed byte load @0x10010005 and unsigned byte load @0x10010005:
   - word becomes 0xDEAD80EF (verify via word load);
   - signed byte load -> 0xFFFFFF80;
   - unsigned byte load -> 0x00000080;
   - store rsp at T+2.
3. Half store 0x1234 @0x10010006, then signed half load @0x10010006 -> word reads 0x123480EF; signed half load returns 0x00001234. Half store 0x9ABC @0x10010006, then signed half load @0x10010006 -> 0xFFFF9ABC.
4. Errors: the following each give rsp_valid at T+1 with err=1, rdata=0, and no RAM change (confirm by reading back word @0x10010004):
   - half load @0x10010001;
   - word store @0x10010002;
   - load @0x0FFFFFFC;
   - load @BASE+0x2000;
   - req_size=11.
5. Back-to-back:
   - req_valid held high with 3 word stores, then 3 loads;
   - accepts occur every cycle for stores and every 2 cycles for loads;
   - exactly one rsp_valid pulse per request, in order.
6. Reset in MERGE: byte store 0xAA @0x10010008 over 0x11223344, rstn low during MERGE -> outputs 0 immediately, state IDLE after release; word load @0x10010008 returns 0x11223344.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: size codes, FSM encoding,
// default RAM base address and the alignment check used at request decode.
package dmem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MERGE = 2'd2
  } state_t;

  // True when size/lane cannot be served (misaligned or illegal size code).
  function automatic logic size_lane_err(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Little-endian sub-word datapath: extracts a sign/zero-extended load value
// from a RAM word and merges sub-word store data into a RAM word.
module dmem_byte_lane
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] ins;

  assign sh      = {lane, 3'b000};
  assign shifted = word >> sh;

  always_comb begin
    rdata = 32'h0;
    case (size)
      SZ_BYTE: rdata = {{24{sign & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata = {{16{sign & shifted[15]}}, shifted[15:0]};
      SZ_WORD: rdata = word;
      default: rdata = 32'h0;
    endcase
  end

  always_comb begin
    mask = 32'h0;
    ins  = 32'h0;
    case (size)
      SZ_BYTE: begin
        mask = 32'h0000_00ff << sh;
        ins  = {24'h0, wdata[7:0]} << sh;
      end
      SZ_HALF: begin
        mask = 32'h0000_ffff << sh;
        ins  = {16'h0, wdata[15:0]} << sh;
      end
      SZ_WORD: begin
        mask = 32'hffff_ffff;
        ins  = wdata;
      end
      default: begin
        mask = 32'h0;
        ins  = 32'h0;
      end
    endcase
    merged = (word & ~mask) | ins;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word RAM with byte/half/word loads and stores,
// read-modify-write for sub-word stores, valid/ready request, pulsed response.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready; word stores and errors complete from here
// ST_LOAD  | RAM word read; extract and respond on the next edge
// ST_MERGE | RAM word read; write merged word and respond on next edge
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] BASE_ADDR  = DMEM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_t state, state_d;

  logic [31:0]           off;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic                  accept;
  logic                  req_bad;
  logic                  word_store;

  logic [ADDR_WIDTH-1:0] r_idx;
  logic [1:0]            r_lane;
  logic [1:0]            r_size;
  logic                  r_sign;
  logic [31:0]           r_wdata;

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rd_word;
  logic        mem_we;
  logic        mem_re;
  logic [ADDR_WIDTH-1:0] mem_widx;
  logic [31:0] mem_wdata;

  logic [31:0] lane_rdata;
  logic [31:0] lane_merged;

  logic        rsp_valid_d;
  logic [31:0] rsp_rdata_d;
  logic        rsp_err_d;

  assign off        = req_addr - BASE_ADDR;
  assign in_range   = (off >> (ADDR_WIDTH + 2)) == 32'd0;
  assign idx        = off[ADDR_WIDTH+1:2];
  assign lane       = off[1:0];
  assign req_ready  = (state == ST_IDLE);
  assign accept     = req_valid & req_ready;
  assign req_bad    = ~in_range | size_lane_err(req_size, lane);
  assign word_store = req_we & (req_size == SZ_WORD);

  // A MERGE write never collides with a new access because ready is low then.
  assign mem_we    = (accept & ~req_bad & word_store) | (state == ST_MERGE);
  assign mem_re    = accept & ~req_bad & ~word_store;
  assign mem_widx  = (state == ST_MERGE) ? r_idx : idx;
  assign mem_wdata = (state == ST_MERGE) ? lane_merged : req_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
    if (mem_re) rd_word <= mem[idx];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx   <= '0;
      r_lane  <= 2'b00;
      r_size  <= SZ_BYTE;
      r_sign  <= 1'b0;
      r_wdata <= 32'h0;
    end else if (accept) begin
      r_idx   <= idx;
      r_lane  <= lane;
      r_size  <= req_size;
      r_sign  <= req_sign;
      r_wdata <= req_wdata;
    end
  end

  dmem_byte_lane u_lane (
    .word   (rd_word),
    .lane   (r_lane),
    .size   (r_size),
    .sign   (r_sign),
    .wdata  (r_wdata),
    .rdata  (lane_rdata),
    .merged (lane_merged)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (word_store) begin
            rsp_valid_d = 1'b1;
          end else if (req_we) begin
            state_d = ST_MERGE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = lane_rdata;
        state_d     = ST_IDLE;
      end
      ST_MERGE: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: hand-computed expectations checked with
// immediate assertions, followed by a single summary line.
module tb_dmem_ctrl;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_mis = 0;

  dmem_ctrl #(.ADDR_WIDTH(11), .BASE_ADDR(32'h1001_0000)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sign  (req_sign),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One request from an idle controller; latency counts cycles from the accept
  // edge to the sampled response (1 = visible right after the accept edge).
  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic sign,
                      input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    bit got;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
    check32({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_size  = 2'b11;
    req_sign  = ~sign;
    req_addr  = 32'h0;
    req_wdata = 32'h5555_5555;
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 4) begin
      if (rsp_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check_int({tag, ".latency"}, got ? lat : -1, exp_lat);
    check32({tag, ".rdata"}, rsp_rdata, exp_rdata);
    check32({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    @(posedge clk);
    #1;
    check32({tag, ".pulse"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, ILL = 2'b11;
  localparam logic [31:0] BA = 32'h1001_0000;

  logic [31:0] bb_addr [6];
  logic [31:0] bb_data [6];
  int          acc_cyc [6];
  logic [31:0] rsp_data [6];

  initial begin
    rstn      = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_sign  = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst.ready", {31'h0, req_ready}, 32'h1);
    check32("rst.valid", {31'h0, rsp_valid}, 32'h0);
    check32("rst.rdata", rsp_rdata, 32'h0);
    check32("rst.err", {31'h0, rsp_err}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // word store / load
    xact("w_st",  1, W, 0, BA + 32'h4, 32'hDEAD_BEEF, 1, 32'h0, 0);
    xact("w_ld",  0, W, 1, BA + 32'h4, 32'h0,         2, 32'hDEAD_BEEF, 0);
    // byte store with RMW
    xact("b_st",  1, B, 1, BA + 32'h5, 32'hFFFF_FF80, 2, 32'h0, 0);
    xact("b_wld", 0, W, 0, BA + 32'h4, 32'h0,         2, 32'hDEAD_80EF, 0);
    xact("b_lds", 0, B, 1, BA + 32'h5, 32'h0,         2, 32'hFFFF_FF80, 0);
    xact("b_ldu", 0, B, 0, BA + 32'h5, 32'h0,         2, 32'h0000_0080, 0);
    // halfword store / load
    xact("h_st1", 1, H, 0, BA + 32'h6, 32'hAAAA_1234, 2, 32'h0, 0);
    xact("h_wld", 0, W, 0, BA + 32'h4, 32'h0,         2, 32'h1234_80EF, 0);
    xact("h_ld1", 0, H, 1, BA + 32'h6, 32'h0,         2, 32'h0000_1234, 0);
    xact("h_st2", 1, H, 0, BA + 32'h6, 32'h0000_9ABC, 2, 32'h0, 0);
    xact("h_lds", 0, H, 1, BA + 32'h6, 32'h0,         2, 32'hFFFF_9ABC, 0);
    xact("h_ldu", 0, H, 0, BA + 32'h6, 32'h0,         2, 32'h0000_9ABC, 0);
    xact("b3_ls", 0, B, 1, BA + 32'h7, 32'h0,         2, 32'hFFFF_FF9A, 0);
    xact("b0_lu", 0, B, 0, BA + 32'h4, 32'h0,         2, 32'h0000_00EF, 0);
    // errors
    xact("e_hmis", 0, H,   1, BA + 32'h1,    32'h0,         1, 32'h0, 1);
    xact("e_wmis", 1, W,   0, BA + 32'h2,    32'h0BAD_0BAD, 1, 32'h0, 1);
    xact("e_low",  0, W,   0, 32'h0FFF_FFFC, 32'h0,         1, 32'h0, 1);
    xact("e_high", 0, W,   0, BA + 32'h2000, 32'h0,         1, 32'h0, 1);
    xact("e_size", 1, ILL, 0, BA + 32'h4,    32'h0BAD_0BAD, 1, 32'h0, 1);
    xact("e_chk",  0, W,   0, BA + 32'h4,    32'h0,         2, 32'h9ABC_80EF, 0);
    // last word in range
    xact("top_st", 1, W, 0, BA + 32'h1FFC, 32'hCAFE_F00D, 1, 32'h0, 0);
    xact("top_ld", 0, W, 0, BA + 32'h1FFC, 32'h0,         2, 32'hCAFE_F00D, 0);

    // back-to-back: 3 word stores then 3 word loads with req_valid held high
    for (int k = 0; k < 3; k++) begin
      bb_addr[k]     = BA + 32'h10 + 32'(4 * k);
      bb_data[k]     = 32'h1111_1111 * 32'(k + 1);
      bb_addr[k + 3] = bb_addr[k];
      bb_data[k + 3] = 32'h0;
    end
    begin
      int i;
      int cyc;
      int nrsp;
      bit accepting;
      i = 0;
      cyc = 0;
      nrsp = 0;
      while ((i < 6 || nrsp < 6) && cyc < 40) begin
        @(negedge clk);
        if (i < 6) begin
          req_valid = 1'b1;
          req_we    = (i < 3);
          req_size  = W;
          req_sign  = 1'b0;
          req_addr  = bb_addr[i];
          req_wdata = bb_data[i];
        end else begin
          req_valid = 1'b0;
        end
        accepting = (i < 6) && req_ready;
        @(posedge clk);
        #1;
        if (accepting) begin
          acc_cyc[i] = cyc;
          i++;
        end
        if (rsp_valid) begin
          if (nrsp < 6) rsp_data[nrsp] = rsp_rdata;
          nrsp++;
        end
        cyc++;
      end
      req_valid = 1'b0;
      repeat (3) begin
        @(posedge clk);
        #1;
        if (rsp_valid) nrsp++;
      end
      check_int("bb.rsp_count", nrsp, 6);
      check_int("bb.acc_st1", acc_cyc[1], 1);
      check_int("bb.acc_st2", acc_cyc[2], 2);
      check_int("bb.acc_ld0", acc_cyc[3], 3);
      check_int("bb.acc_ld1", acc_cyc[4], 5);
      check_int("bb.acc_ld2", acc_cyc[5], 7);
      check32("bb.st_rdata", rsp_data[2], 32'h0);
      check32("bb.ld0", rsp_data[3], 32'h1111_1111);
      check32("bb.ld1", rsp_data[4], 32'h2222_2222);
      check32("bb.ld2", rsp_data[5], 32'h3333_3333);
    end

    // reset while in MERGE abandons the pending write
    xact("r_pre", 1, W, 0, BA + 32'h8, 32'h1122_3344, 1, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = B;
    req_sign  = 1'b0;
    req_addr  = BA + 32'h8;
    req_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check32("r_merge.ready", {31'h0, req_ready}, 32'h0);
    #1;
    rstn = 1'b0;
    #1;
    check32("r_rst.ready", {31'h0, req_ready}, 32'h1);
    check32("r_rst.valid", {31'h0, rsp_valid}, 32'h0);
    check32("r_rst.rdata", rsp_rdata, 32'h0);
    check32("r_rst.err", {31'h0, rsp_err}, 32'h0);
    @(posedge clk);
    #1;
    check32("r_rst.valid2", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    xact("r_post", 0, W, 0, BA + 32'h8, 32'h0, 2, 32'h1122_3344, 0);
    xact("r_keep", 0, W, 0, BA + 32'h4, 32'h0, 2, 32'h9ABC_80EF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
